// File: rtl/sorted_array_writer.sv
// ---------------------------------------------------------------------------
// sorted_array_writer
//   Maintains an ascending-sorted array in a DEPTH x WIDTH synchronous RAM.
//   Values arrive one at a time on a valid/ready handshake and are placed by
//   insertion sort: entries larger than the new value are shifted up one slot,
//   walking down from the top, and the new value is written into the gap.
//   Equal values land after existing duplicates (stable insertion).
//   A search-side read port reads the RAM whenever the block is idle.
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-high
//   i_in_valid in   1      producer offers i_in_data
//   i_in_data  in   WIDTH  value to insert
//   o_in_ready out  1      value accepted this cycle when i_in_valid is high
//   i_clear    in   1      empty the array (idle only)
//   i_rd_addr  in   AW     search-side read address
//   o_rd_data  out  WIDTH  mem[i_rd_addr], one cycle after the address
//   o_count    out  CW     number of valid entries (slots 0..count-1)
//   o_full     out  1      count == DEPTH
//   o_busy     out  1      insertion in progress
//   o_ins_done out  1      one-cycle pulse when an insertion finishes
//   o_ins_addr out  AW     slot of the most recently inserted value
// ---------------------------------------------------------------------------
module sorted_array_writer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    input  logic             i_clear,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_busy,
    output logic             o_ins_done,
    output logic [AW-1:0]    o_ins_addr
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WT   = 3'd2,
        ST_CMP  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] A_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};
    localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;
    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_i;
    logic [AW-1:0]    r_pos;
    logic [WIDTH-1:0] r_val;
    logic [AW-1:0]    r_ins_addr;
    logic             r_busy;
    logic             r_ins_done;

    logic             w_full;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_shift;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [AW-1:0]    w_raddr;
    logic [AW-1:0]    w_i_init;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_in_ready = (r_state == ST_IDLE) && !w_full && !i_clear;
    assign w_accept   = i_in_valid && w_in_ready;
    // Top occupied slot; only used when count != 0, so no underflow matters.
    assign w_i_init   = AW'(r_count - C_ONE);
    // In CMP the RAM output is mem[i]; a larger entry moves up one slot.
    assign w_shift    = (r_state == ST_CMP) && (r_q > r_val);

    // Write-port and read-address selection; the insertion walk owns the read port while busy.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_pos;
        w_wdata = r_val;
        if (w_shift) begin
            w_we    = 1'b1;
            w_waddr = r_i + A_ONE;
            w_wdata = r_q;
        end else if (r_state == ST_WR) begin
            w_we    = 1'b1;
            w_waddr = r_pos;
            w_wdata = r_val;
        end else begin
            w_we    = 1'b0;
        end
        if (r_state == ST_IDLE) begin
            w_raddr = i_rd_addr;
        end else begin
            w_raddr = r_i;
        end
    end

    // Synchronous RAM: one write port, one registered read port; contents never reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_q <= r_mem[w_raddr];
    end

    // Insertion controller with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= C_ZERO;
            r_i        <= A_ZERO;
            r_pos      <= A_ZERO;
            r_val      <= {WIDTH{1'b0}};
            r_ins_addr <= A_ZERO;
            r_busy     <= 1'b0;
            r_ins_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ins_done <= 1'b0;
                    if (i_clear) begin
                        r_count <= C_ZERO;
                    end else if (w_accept) begin
                        r_val  <= i_in_data;
                        r_busy <= 1'b1;
                        if (r_count == C_ZERO) begin
                            r_pos   <= A_ZERO;
                            r_state <= ST_WR;
                        end else begin
                            r_i     <= w_i_init;
                            r_state <= ST_RD;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    r_state <= ST_WT;
                end
                ST_WT: begin
                    r_state <= ST_CMP;
                end
                ST_CMP: begin
                    if (r_q > r_val) begin
                        if (r_i == A_ZERO) begin
                            r_pos   <= A_ZERO;
                            r_state <= ST_WR;
                        end else begin
                            r_i     <= r_i - A_ONE;
                            r_state <= ST_RD;
                        end
                    end else begin
                        // Stop at the first entry <= val: duplicates stay ahead of the new value.
                        r_pos   <= r_i + A_ONE;
                        r_state <= ST_WR;
                    end
                end
                ST_WR: begin
                    r_count    <= r_count + C_ONE;
                    r_ins_addr <= r_pos;
                    r_ins_done <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    r_ins_done <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_ins_done <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready = w_in_ready;
    assign o_rd_data  = r_q;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_busy     = r_busy;
    assign o_ins_done = r_ins_done;
    assign o_ins_addr = r_ins_addr;

endmodule

// File: tb/tb_sorted_array_writer.sv
// Directed bench for sorted_array_writer with DEPTH=8, WIDTH=8.
module tb_sorted_array_writer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;

    logic             clk;
    logic             reset;
    logic             i_in_valid;
    logic [WIDTH-1:0] i_in_data;
    logic             o_in_ready;
    logic             i_clear;
    logic [AW-1:0]    i_rd_addr;
    logic [WIDTH-1:0] o_rd_data;
    logic [CW-1:0]    o_count;
    logic             o_full;
    logic             o_busy;
    logic             o_ins_done;
    logic [AW-1:0]    o_ins_addr;

    int n_chk;
    int n_err;

    sorted_array_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_in_valid (i_in_valid),
        .i_in_data  (i_in_data),
        .o_in_ready (o_in_ready),
        .i_clear    (i_clear),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_busy     (o_busy),
        .o_ins_done (o_ins_done),
        .o_ins_addr (o_ins_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Insert one value; checks busy duration, single ins_done pulse and slot.
    task automatic insert(input logic [7:0] v, input int exp_addr, input int exp_cycles,
                          input logic clear_while_busy);
        int n;
        int pulses;
        logic [AW-1:0] addr;
        n = 0;
        while (!o_in_ready && n < 50) begin
            step();
            n++;
        end
        check_eq("ready_before_insert", {31'd0, o_in_ready}, 32'd1);
        i_in_valid = 1'b1;
        i_in_data  = v;
        step();
        i_in_valid = 1'b0;
        i_clear    = clear_while_busy;
        n = 0;
        pulses = 0;
        addr = '0;
        while (o_busy && n < 100) begin
            if (o_ins_done) begin
                pulses++;
                addr = o_ins_addr;
            end
            n++;
            step();
        end
        i_clear = 1'b0;
        check_eq("busy_cycles", n, exp_cycles);
        check_eq("ins_done_pulses", pulses, 32'd1);
        check_eq("ins_addr", {29'd0, addr}, exp_addr);
        check_eq("ins_addr_held", {29'd0, o_ins_addr}, exp_addr);
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [7:0] exp);
        i_rd_addr = a;
        step();
        check_eq("rd_data", {24'd0, o_rd_data}, {24'd0, exp});
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check_eq("count_after_clear", {28'd0, o_count}, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        i_in_valid = 1'b0;
        i_in_data = '0;
        i_clear = 1'b0;
        i_rd_addr = '0;
        step();
        step();
        reset = 1'b0;
        step();

        // 1: reset state and first insertion into empty array
        check_eq("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
        check_eq("rst_count", {28'd0, o_count}, 32'd0);
        check_eq("rst_full", {31'd0, o_full}, 32'd0);
        check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
        check_eq("rst_ins_done", {31'd0, o_ins_done}, 32'd0);
        check_eq("rst_ins_addr", {29'd0, o_ins_addr}, 32'd0);
        insert(8'd5, 0, 2, 1'b0);
        check_eq("t1_count", {28'd0, o_count}, 32'd1);
        read_chk(3'd0, 8'd5);

        // 2: 10, 30, 20
        do_clear();
        insert(8'd10, 0, 2, 1'b0);
        insert(8'd30, 1, 5, 1'b0);
        insert(8'd20, 1, 8, 1'b0);
        check_eq("t2_count", {28'd0, o_count}, 32'd3);
        read_chk(3'd0, 8'd10);
        read_chk(3'd1, 8'd20);
        read_chk(3'd2, 8'd30);

        // 3: descending fill, every insertion shifts all existing entries
        do_clear();
        for (int k = 0; k < DEPTH; k++) begin
            insert(8'(DEPTH - k), 0, 3 * k + 2, 1'b0);
        end
        check_eq("t3_full", {31'd0, o_full}, 32'd1);
        check_eq("t3_in_ready", {31'd0, o_in_ready}, 32'd0);
        i_in_valid = 1'b1;
        i_in_data = 8'd9;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("t3_no_accept_busy", {31'd0, o_busy}, 32'd0);
        end
        i_in_valid = 1'b0;
        check_eq("t3_count", {28'd0, o_count}, 32'd8);
        for (int k = 0; k < DEPTH; k++) begin
            read_chk(3'(k), 8'(k + 1));
        end

        // 4: duplicates insert after existing equals
        do_clear();
        insert(8'd4, 0, 2, 1'b0);
        insert(8'd4, 1, 5, 1'b0);
        insert(8'd4, 2, 5, 1'b0);
        check_eq("t4_count", {28'd0, o_count}, 32'd3);

        // 5: clear with in_valid blocks acceptance; clear while busy ignored
        i_in_valid = 1'b1;
        i_in_data = 8'd7;
        i_clear = 1'b1;
        #1;
        check_eq("t5_ready_during_clear", {31'd0, o_in_ready}, 32'd0);
        step();
        i_in_valid = 1'b0;
        i_clear = 1'b0;
        check_eq("t5_no_accept_busy", {31'd0, o_busy}, 32'd0);
        check_eq("t5_count_cleared", {28'd0, o_count}, 32'd0);
        insert(8'd1, 0, 2, 1'b0);
        insert(8'd0, 0, 5, 1'b1);
        check_eq("t5_count_after_busy_clear", {28'd0, o_count}, 32'd2);
        read_chk(3'd0, 8'd0);
        read_chk(3'd1, 8'd1);

        // 6: reset during CMP of a 3-element shift
        do_clear();
        insert(8'd10, 0, 2, 1'b0);
        insert(8'd20, 1, 5, 1'b0);
        insert(8'd30, 2, 5, 1'b0);
        i_in_valid = 1'b1;
        i_in_data = 8'd5;
        step();          // now RD
        i_in_valid = 1'b0;
        step();          // WT
        step();          // CMP
        check_eq("t6_busy_in_cmp", {31'd0, o_busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_busy", {31'd0, o_busy}, 32'd0);
        check_eq("t6_count", {28'd0, o_count}, 32'd0);
        check_eq("t6_in_ready", {31'd0, o_in_ready}, 32'd1);
        check_eq("t6_ins_done", {31'd0, o_ins_done}, 32'd0);
        step();
        check_eq("t6_ins_done_later", {31'd0, o_ins_done}, 32'd0);
        check_eq("t6_busy_later", {31'd0, o_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
